mirfak_bus_arbiter: RTL

Two-master to one-slave Wishbone arbiter sharing a single memory port between the Mirfak fetch unit (instruction port) and the load/store unit (data port). Sits between the core's `iwbm_*`/`dwbm_*` ports and the external bus. Grants whole bus cycles (held while the granted master keeps `cyc` high), alternates round-robin under contention, and terminates hung transfers with a bus error after a programmable timeout.

---
 rtl/mirfak_defines_pkg.sv | 25 ++
 rtl/mirfak_bus_timeout.sv | 32 +++
 rtl/mirfak_bus_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mirfak_defines_pkg.sv
// Shared Mirfak core definitions: exception causes, bus arbiter states and timeout defaults.
package mirfak_defines_pkg;

  localparam logic [3:0] ExcInstrAccessFault = 4'd1;
  localparam logic [3:0] ExcLoadAccessFault  = 4'd5;
  localparam logic [3:0] ExcStoreAccessFault = 4'd7;

  localparam int unsigned BusTimeoutDefault = 1023;

  localparam logic [2:0] ArbIdleOh = 3'b001;
  localparam logic [2:0] ArbGntIOh = 3'b010;
  localparam logic [2:0] ArbGntDOh = 3'b100;

  typedef enum logic [2:0] {
    ArbIdle = ArbIdleOh,
    ArbGntI = ArbGntIOh,
    ArbGntD = ArbGntDOh
  } arb_state_e;

  // A zero timeout still needs a 1-bit counter to stay legal.
  function automatic int unsigned bus_timer_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mirfak_bus_timeout.sv
// Watchdog counting unterminated strobe cycles; pulses expire on the TIMEOUT-th one.
module mirfak_bus_timeout
  import mirfak_defines_pkg::*;
#(
  parameter int unsigned TIMEOUT = BusTimeoutDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int unsigned W = bus_timer_width(TIMEOUT);
  localparam logic [W-1:0] LastCount = W'(TIMEOUT - 1);

  logic [W-1:0] r_count;

  // Expire fires in the cycle that would bring the count to TIMEOUT.
  assign expire_o = (TIMEOUT != 0) && enable_i && (r_count == LastCount);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clear_i || expire_o) begin
      r_count <= '0;
    end else if (enable_i) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/mirfak_bus_arbiter.sv
// Two-master Wishbone arbiter: instruction and data ports share one slave bus,
// whole-cycle grants, round-robin under contention, bus-error on hung transfers.
module mirfak_bus_arbiter
  import mirfak_defines_pkg::*;
#(
  parameter int unsigned TIMEOUT = BusTimeoutDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iwbs_addr_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic        dwbs_we_i,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  arb_state_e r_state;
  logic       r_last_d;
  logic       w_gnt_stb;
  logic       w_term;
  logic       w_expire;

  assign w_term    = wbm_ack_i | wbm_err_i;
  assign w_gnt_stb = ((r_state == ArbGntI) & iwbs_stb_i) | ((r_state == ArbGntD) & dwbs_stb_i);

  mirfak_bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (w_gnt_stb & ~w_term),
    .clear_i  (~w_gnt_stb | w_term),
    .expire_o (w_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ArbIdle;
      r_last_d <= 1'b0;
    end else begin
      unique case (r_state)
        ArbIdle: begin
          // Data wins unless it was the last master served and instruction is waiting.
          if (dwbs_cyc_i && (!iwbs_cyc_i || !r_last_d)) begin
            r_state  <= ArbGntD;
            r_last_d <= 1'b1;
          end else if (iwbs_cyc_i) begin
            r_state  <= ArbGntI;
            r_last_d <= 1'b0;
          end
        end
        ArbGntI: if (!iwbs_cyc_i) r_state <= ArbIdle;
        ArbGntD: if (!dwbs_cyc_i) r_state <= ArbIdle;
        default: r_state <= ArbIdle;
      endcase
    end
  end

  // Read data is shared; held at zero only while reset is asserted.
  assign iwbs_dat_o = rst_i ? 32'h0 : wbm_dat_i;
  assign dwbs_dat_o = rst_i ? 32'h0 : wbm_dat_i;

  always_comb begin
    wbm_addr_o = 32'h0;
    wbm_dat_o  = 32'h0;
    wbm_sel_o  = 4'h0;
    wbm_we_o   = 1'b0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    iwbs_ack_o = 1'b0;
    iwbs_err_o = 1'b0;
    dwbs_ack_o = 1'b0;
    dwbs_err_o = 1'b0;
    unique case (r_state)
      ArbGntI: begin
        wbm_addr_o = iwbs_addr_i;
        wbm_sel_o  = 4'hF;
        wbm_cyc_o  = iwbs_cyc_i & ~w_expire;
        wbm_stb_o  = iwbs_stb_i & ~w_expire;
        iwbs_ack_o = wbm_ack_i;
        iwbs_err_o = wbm_err_i | w_expire;
      end
      ArbGntD: begin
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_we_o   = dwbs_we_i;
        wbm_cyc_o  = dwbs_cyc_i & ~w_expire;
        wbm_stb_o  = dwbs_stb_i & ~w_expire;
        dwbs_ack_o = wbm_ack_i;
        dwbs_err_o = wbm_err_i | w_expire;
      end
      default: ;
    endcase
  end

endmodule
